state_update_scheduler: RTL and testbench
=========================================

Name: state_update_scheduler

Overview:
Sequences the state-register bank (3-bit index, 3-bit value, UpState/DownState pulse inputs) and shares it between two requesters: a user/button request port and a periodic decay timer. Sits between the input FSM drivers and the state register. One requester owns the bank at a time. Every increment or decrement is one single-cycle pulse, issued only after the addressed value has settled.

Parameters:
NUM_STATES, 5, number of valid register indices (0..NUM_STATES-1, max 8)
TICK_DIV, 16, clk cycles per decay tick (board build overrides with a large value)
VAL_MAX, 7, saturation ceiling of a register value
IDX_W, 3, index width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
tick_en  in  1  enables the decay timer
req_valid  in  1  user request present; held until accepted
req_dir  in  1  1 = increment, 0 = decrement
req_idx  in  IDX_W  target register index
req_ready  out  1  high only in IDLE; accept = req_valid & req_ready at a rising edge
stateValue  in  3  value of the register currently addressed by state (combinational from bank)
state  out  IDX_W  index driven to the bank
UpState  out  1  one-cycle increment pulse
DownState  out  1  one-cycle decrement pulse
decay_tick  out  1  one-cycle pulse on timer wrap
busy  out  1  high in any non-IDLE state
nop  out  1  one-cycle pulse when a user request is suppressed

Behaviour:
- Reset (async, immediate): FSM = IDLE; state = 0; UpState, DownState, decay_tick and nop = 0; counter = 0; pending = 0. req_ready = 1 from the first edge after release.
- Timer: counter runs 0..TICK_DIV-1 while tick_en = 1. At the wrap it pulses decay_tick and sets pending. If tick_en = 0, the counter clears and holds; an already-set pending is still serviced. A tick during a decay walk re-sets pending, and multiple ticks merge into one.
- FSM states: IDLE, USER_SETUP, USER_PULSE, DECAY_SETUP, DECAY_PULSE.
- In IDLE, decay has priority:
  - pending = 1: go to DECAY_SETUP with walk index 0, and clear pending on entry.
  - Otherwise, on an accepted request: latch dir and idx, go to USER_SETUP.
- USER_SETUP (1 cycle): state = latched idx.
- USER_PULSE (1 cycle), then IDLE:
  - Increment: UpState = 1 if stateValue < VAL_MAX.
  - Decrement: DownState = 1 if stateValue > 0.
  - If saturated, or idx >= NUM_STATES: no pulse, nop = 1.
  - Latency: pulse in the 2nd cycle after the accepting edge; req_ready is low for 2 cycles.
- DECAY_SETUP: state = walk index.
- DECAY_PULSE: DownState = 1 iff stateValue != 0; no nop. Then either increment the index and return to DECAY_SETUP, or go to IDLE after index NUM_STATES-1. A full walk takes 2*NUM_STATES cycles, with busy high throughout.
- UpState and DownState are never high together, and never in SETUP or IDLE.
- state holds its last value in IDLE.
- A held req_valid is accepted on the first IDLE cycle with pending = 0. Worst-case wait is 2*NUM_STATES + 2 cycles.
- Reset mid-operation: pulses drop immediately, an in-flight request is discarded, and pending is lost.

Decomposition:
- Package state_sched_pkg holds:
  - the FSM state enum (3-bit encoding);
  - constants IDX_W = 3, VAL_W = 3, VAL_MAX = 7;
  - the direction encodings DIR_UP = 1, DIR_DN = 0.
- One sub-module, decay_tick_gen: parameterised TICK_DIV counter with tick_en and decay_tick output. pending lives in the scheduler.

Test Plan:
- Reset: hold rst = 0 mid-cycle -> all outputs 0 immediately. Release -> req_ready = 1 at the next edge, with no pulses for 15 cycles (tick_en = 0).
- User increment: idx = 2, bank value 3, req_dir = 1 -> state = 2 in cycle 1 after accept. UpState = 1 only in cycle 2. req_ready low for cycles 1-2. Bank reads 4 afterwards.
- Saturation: increment at idx 1 with value 7 -> UpState stays 0, nop = 1 for one cycle. Decrement at value 0 -> DownState stays 0, nop = 1. Request with idx = 6 -> nop = 1, no pulse.
- Decay walk: tick_en = 1, values {0,4,7,1,2} -> decay_tick in cycle 16. DownState pulses for indices 1, 2, 3, 4 only. busy is high for 10 cycles. Final values {0,3,6,0,1}.
- Collision: req_valid held on the same edge pending sets -> decay walk runs first (10 cycles), the request is accepted in the following IDLE cycle, and its pulse comes 2 cycles later.
- Reset mid-walk: rst low during DECAY_PULSE at index 2 -> DownState falls immediately. After release, pending = 0, and no DownState occurs until the next decay_tick 16 cycles after release.

Source files
------------

// File: rtl/state_sched_pkg.sv
// rtl/state_sched_pkg.sv - shared types and constants for the state-bank update scheduler
//
// Contents:
//   sched_state_e : scheduler FSM state encoding (3 bits)
//   IDX_W         : width of a state-bank register index
//   VAL_W         : width of a state-bank register value
//   VAL_MAX       : saturation ceiling of a register value
//   DIR_UP/DIR_DN : request direction encodings
package state_sched_pkg;

    localparam int IDX_W   = 3;
    localparam int VAL_W   = 3;
    localparam int VAL_MAX = 7;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_USER_SETUP  = 3'd1,
        ST_USER_PULSE  = 3'd2,
        ST_DECAY_SETUP = 3'd3,
        ST_DECAY_PULSE = 3'd4
    } sched_state_e;

endpackage

// File: rtl/decay_tick_gen.sv
// rtl/decay_tick_gen.sv - free-running decay timer producing a one-cycle tick per TICK_DIV cycles
//
// Ports:
//   clk_i        : system clock, rising edge
//   rst_ni       : asynchronous active-low reset
//   tick_en_i    : counter runs while high; cleared and held while low
//   decay_tick_o : registered one-cycle pulse on each counter wrap
module decay_tick_gen #(
    parameter int TICK_DIV = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic tick_en_i,
    output logic decay_tick_o
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;

    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (!tick_en_i) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d  = '0;
            tick_d = 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign decay_tick_o = tick_q;

endmodule

// File: rtl/state_update_scheduler.sv
// rtl/state_update_scheduler.sv - arbitrates user requests and periodic decay over the state-register bank
//
// Ports:
//   clk         : system clock, rising edge
//   rst         : asynchronous active-low reset
//   tick_en     : enables the decay timer
//   req_valid   : user request present, held until accepted
//   req_dir     : 1 = increment, 0 = decrement
//   req_idx     : target register index
//   req_ready   : request can be accepted this cycle (IDLE, no decay due)
//   stateValue  : value of the register addressed by state
//   state       : index driven to the bank
//   UpState     : one-cycle increment pulse
//   DownState   : one-cycle decrement pulse
//   decay_tick  : one-cycle pulse on timer wrap
//   busy        : FSM is outside IDLE
//   nop         : one-cycle pulse when a user request is suppressed
module state_update_scheduler #(
    parameter int NUM_STATES = 5,
    parameter int TICK_DIV   = 16,
    parameter int VAL_MAX    = state_sched_pkg::VAL_MAX,
    parameter int IDX_W      = state_sched_pkg::IDX_W
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             tick_en,
    input  logic                             req_valid,
    input  logic                             req_dir,
    input  logic [IDX_W-1:0]                 req_idx,
    output logic                             req_ready,
    input  logic [state_sched_pkg::VAL_W-1:0] stateValue,
    output logic [IDX_W-1:0]                 state,
    output logic                             UpState,
    output logic                             DownState,
    output logic                             decay_tick,
    output logic                             busy,
    output logic                             nop
);

    import state_sched_pkg::*;

    sched_state_e     fsm_q, fsm_d;
    logic [IDX_W-1:0] state_q, state_d;
    logic             dir_q, dir_d;
    logic             pending_q, pending_d;
    logic             ready_en_q;

    logic tick;
    logic decay_req;
    logic accept;
    logic idx_ok;
    logic can_up;
    logic can_dn;
    logic last_idx;
    logic user_up;
    logic user_dn;

    decay_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk_i        (clk),
        .rst_ni       (rst),
        .tick_en_i    (tick_en),
        .decay_tick_o (tick)
    );

    // A tick arriving in IDLE counts as pending right away, so a request
    // presented in the same cycle never overtakes the decay walk.
    assign decay_req = pending_q | tick;
    assign accept    = req_valid & req_ready;

    assign idx_ok   = int'(state_q) < NUM_STATES;
    assign can_up   = int'(stateValue) < VAL_MAX;
    assign can_dn   = stateValue != '0;
    assign last_idx = int'(state_q) == (NUM_STATES - 1);

    assign user_up = (dir_q == DIR_UP) & idx_ok & can_up;
    assign user_dn = (dir_q == DIR_DN) & idx_ok & can_dn;

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm_q <= ST_IDLE;
        end else begin
            fsm_q <= fsm_d;
        end
    end

    // FSM next state
    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            ST_IDLE: begin
                if (decay_req) begin
                    fsm_d = ST_DECAY_SETUP;
                end else if (accept) begin
                    fsm_d = ST_USER_SETUP;
                end
            end
            ST_USER_SETUP:  fsm_d = ST_USER_PULSE;
            ST_USER_PULSE:  fsm_d = ST_IDLE;
            ST_DECAY_SETUP: fsm_d = ST_DECAY_PULSE;
            ST_DECAY_PULSE: fsm_d = last_idx ? ST_IDLE : ST_DECAY_SETUP;
            default:        fsm_d = ST_IDLE;
        endcase
    end

    // FSM outputs; pulses are gated by the settled bank value in the PULSE states
    always_comb begin
        req_ready = ready_en_q & (fsm_q == ST_IDLE) & ~decay_req;
        busy      = fsm_q != ST_IDLE;
        UpState   = 1'b0;
        DownState = 1'b0;
        nop       = 1'b0;
        case (fsm_q)
            ST_USER_PULSE: begin
                UpState   = user_up;
                DownState = user_dn;
                nop       = ~(user_up | user_dn);
            end
            ST_DECAY_PULSE: begin
                DownState = can_dn;
            end
            default: ;
        endcase
    end

    // Datapath next state: bank index, latched direction and pending tick.
    // The index register doubles as the decay walk counter.
    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        pending_d = pending_q | tick;
        case (fsm_q)
            ST_IDLE: begin
                if (decay_req) begin
                    state_d   = '0;
                    pending_d = 1'b0;
                end else if (accept) begin
                    state_d = req_idx;
                    dir_d   = req_dir;
                end
            end
            ST_DECAY_PULSE: begin
                if (!last_idx) begin
                    state_d = state_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    // ready_en_q keeps req_ready low while reset is asserted and until the
    // first clock edge after release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= '0;
            dir_q      <= 1'b0;
            pending_q  <= 1'b0;
            ready_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            pending_q  <= pending_d;
            ready_en_q <= 1'b1;
        end
    end

    assign state      = state_q;
    assign decay_tick = tick;

endmodule

// File: tb/tb_state_update_scheduler.sv
// tb/tb_state_update_scheduler.sv - directed self-checking bench for state_update_scheduler
module tb_state_update_scheduler;

    logic       clk       = 1'b0;
    logic       rst       = 1'b0;
    logic       tick_en   = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_dir   = 1'b0;
    logic [2:0] req_idx   = 3'd0;
    logic       req_ready;
    logic [2:0] stateValue;
    logic [2:0] state;
    logic       UpState;
    logic       DownState;
    logic       decay_tick;
    logic       busy;
    logic       nop;

    logic [2:0] bank      [0:7];
    logic [2:0] load_vals [0:7];
    logic       load = 1'b0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    state_update_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .tick_en    (tick_en),
        .req_valid  (req_valid),
        .req_dir    (req_dir),
        .req_idx    (req_idx),
        .req_ready  (req_ready),
        .stateValue (stateValue),
        .state      (state),
        .UpState    (UpState),
        .DownState  (DownState),
        .decay_tick (decay_tick),
        .busy       (busy),
        .nop        (nop)
    );

    // State-register bank the scheduler drives.
    assign stateValue = bank[state];

    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 8; i++) bank[i] <= load_vals[i];
        end else if (UpState) begin
            bank[state] <= bank[state] + 3'd1;
        end else if (DownState) begin
            bank[state] <= bank[state] - 3'd1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        #2;
    endtask

    task automatic load_bank(input logic [2:0] v0, input logic [2:0] v1, input logic [2:0] v2,
                             input logic [2:0] v3, input logic [2:0] v4);
        load_vals[0] = v0;
        load_vals[1] = v1;
        load_vals[2] = v2;
        load_vals[3] = v3;
        load_vals[4] = v4;
        for (int i = 5; i < 8; i++) load_vals[i] = 3'd0;
        load = 1'b1;
        cyc;
        load = 1'b0;
    endtask

    task automatic user_req(input string tag, input logic dir, input logic [2:0] idx,
                            input logic exp_up, input logic exp_dn, input logic exp_nop);
        req_valid = 1'b1;
        req_dir   = dir;
        req_idx   = idx;
        chk({tag, "_rdy0"}, req_ready, 1);
        cyc;
        req_valid = 1'b0;
        chk({tag, "_state1"}, state, idx);
        chk({tag, "_rdy1"}, req_ready, 0);
        chk({tag, "_pulse1"}, {UpState, DownState, nop}, 0);
        cyc;
        chk({tag, "_rdy2"}, req_ready, 0);
        chk({tag, "_up2"}, UpState, exp_up);
        chk({tag, "_dn2"}, DownState, exp_dn);
        chk({tag, "_nop2"}, nop, exp_nop);
        cyc;
        chk({tag, "_rdy3"}, req_ready, 1);
        chk({tag, "_pulse3"}, {UpState, DownState, nop}, 0);
        chk({tag, "_hold3"}, state, idx);
    endtask

    task automatic wait_tick(output int k, output int downs);
        k     = -1;
        downs = 0;
        for (int i = 1; i <= 40; i++) begin
            cyc;
            if (decay_tick) begin
                k = i;
                break;
            end
            if (DownState) downs++;
        end
    endtask

    initial begin
        int k;
        int d;
        int quiet;
        int busy_cnt;
        int ups;
        int nops;
        int acc;
        int upat;
        logic [4:0] mask;
        logic [2:0] exp_v [0:4];

        // Reset held: bank preloaded with zeros while the DUT is in reset.
        for (int i = 0; i < 8; i++) load_vals[i] = 3'd0;
        load = 1'b1;
        cyc;
        cyc;
        load = 1'b0;
        chk("rst_ready", req_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pulses", {UpState, DownState, nop, decay_tick}, 0);
        chk("rst_state", state, 0);
        rst = 1'b1;
        chk("rel_ready_pre", req_ready, 0);
        cyc;
        chk("rel_ready", req_ready, 1);
        quiet = 0;
        repeat (15) begin
            cyc;
            if (UpState || DownState || nop || busy || decay_tick) quiet++;
        end
        chk("rel_quiet", quiet, 0);

        // User requests.
        load_bank(3'd0, 3'd0, 3'd3, 3'd5, 3'd0);
        user_req("inc", 1'b1, 3'd2, 1'b1, 1'b0, 1'b0);
        chk("inc_bank", bank[2], 4);
        load_bank(3'd0, 3'd7, 3'd0, 3'd5, 3'd0);
        user_req("sat_up", 1'b1, 3'd1, 1'b0, 1'b0, 1'b1);
        user_req("sat_dn", 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
        user_req("bad_idx", 1'b1, 3'd6, 1'b0, 1'b0, 1'b1);
        user_req("dec", 1'b0, 3'd3, 1'b0, 1'b1, 1'b0);
        chk("dec_bank", bank[3], 4);
        chk("sat_bank", bank[1], 7);

        // Decay walk.
        load_bank(3'd0, 3'd4, 3'd7, 3'd1, 3'd2);
        tick_en = 1'b1;
        wait_tick(k, d);
        chk("walk_tick_cycle", k, 16);
        chk("walk_ready_tick", req_ready, 0);
        tick_en  = 1'b0;
        busy_cnt = 0;
        ups      = 0;
        nops     = 0;
        mask     = '0;
        for (int j = 1; j <= 14; j++) begin
            cyc;
            if (j == 1) chk("walk_first_state", {busy, state}, {1'b1, 3'd0});
            if (busy) busy_cnt++;
            if (UpState) ups++;
            if (nop) nops++;
            if (DownState) mask[state] = 1'b1;
        end
        chk("walk_busy", busy_cnt, 10);
        chk("walk_mask", mask, 5'b11110);
        chk("walk_up", ups, 0);
        chk("walk_nop", nops, 0);
        exp_v = '{3'd0, 3'd3, 3'd6, 3'd0, 3'd1};
        for (int i = 0; i < 5; i++) chk($sformatf("walk_val%0d", i), bank[i], exp_v[i]);

        // Collision: request presented in the tick cycle waits for the walk.
        load_bank(3'd1, 3'd1, 3'd1, 3'd1, 3'd1);
        tick_en = 1'b1;
        wait_tick(k, d);
        chk("col_tick_cycle", k, 16);
        req_valid = 1'b1;
        req_dir   = 1'b1;
        req_idx   = 3'd2;
        tick_en   = 1'b0;
        chk("col_ready_tick", req_ready, 0);
        acc  = -1;
        upat = -1;
        d    = 0;
        for (int j = 1; j <= 16; j++) begin
            cyc;
            if (acc >= 0 && req_valid) req_valid = 1'b0;
            if (req_valid && req_ready && acc < 0) acc = j;
            if (UpState) upat = j;
            if (DownState) d++;
        end
        req_valid = 1'b0;
        chk("col_accept", acc, 11);
        chk("col_up", upat, 13);
        chk("col_downs", d, 5);
        chk("col_bank2", bank[2], 1);
        chk("col_bank0", bank[0], 0);

        // Reset during DECAY_PULSE at index 2.
        load_bank(3'd3, 3'd3, 3'd3, 3'd3, 3'd3);
        tick_en = 1'b1;
        wait_tick(k, d);
        chk("mid_tick_cycle", k, 16);
        repeat (6) cyc;
        chk("mid_pulse", {busy, DownState, state}, {1'b1, 1'b1, 3'd2});
        #1;
        rst = 1'b0;
        #1;
        chk("mid_rst_dn", DownState, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_state", state, 0);
        cyc;
        rst = 1'b1;
        chk("mid_bank1", bank[1], 2);
        chk("mid_bank2", bank[2], 3);
        wait_tick(k, d);
        chk("mid_next_tick", k, 16);
        chk("mid_no_down", d, 0);
        tick_en = 1'b0;
        repeat (12) cyc;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
